// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and constants for the bit-serial subtractor.
//            - state_e   : controller state encoding (IDLE / RUN / DONE)
//            - WIDTH_MAX : largest operand width the subtractor accepts
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_half_sub.sv
`default_nettype none
// ============================================================================
// Module   : half_sub
// Purpose  : One-bit half subtractor, the subtracting counterpart of the
//            half adder. Computes a - b on single bits.
// Ports    : diff  (out) - a XOR b
//            b_out (out) - borrow, set when a=0 and b=1
//            a     (in)  - minuend bit
//            b     (in)  - subtrahend bit
//            Outputs come first, mirroring the half adder's port order.
// Revision : 1.0 - initial release
// ============================================================================
module half_sub (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b
);

  assign diff  = a ^ b;
  assign b_out = ~a & b;

endmodule : half_sub
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Purpose  : Bit-serial unsigned subtractor computing (a_in - b_in) one bit
//            per clock, LSB first, with a single borrow flop. A start/busy/
//            done handshake issues operands and returns a parallel result.
// Ports    : clk        (in)  - clock, rising edge
//            rst_n      (in)  - asynchronous active-low reset
//            start      (in)  - request new operation (IDLE or DONE only)
//            a_in       (in)  - minuend, captured on the accepting edge
//            b_in       (in)  - subtrahend, captured on the accepting edge
//            busy       (out) - high while the operation runs
//            done       (out) - one-cycle pulse, result valid
//            diff       (out) - (a - b) mod 2^WIDTH, held until next start
//            borrow_out (out) - final borrow, 1 iff a < b
//            diff_bit   (out) - serial difference bit, 0 outside RUN
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             diff_bit
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_sub: WIDTH out of range 1..32");
  end

  state_e             state_q,      state_d;
  logic [WIDTH-1:0]   a_sh_q,       a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,       b_sh_d;
  logic [WIDTH-1:0]   r_sh_q,       r_sh_d;
  logic               br_q,         br_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic [WIDTH-1:0]   diff_q,       diff_d;
  logic               borrow_out_q, borrow_out_d;

  // Full-subtract step built from two half subtractors.
  logic t, b1, d, b2;
  logic [WIDTH-1:0] r_sh_next;

  half_sub u_hs_ab (
    .diff  (t),
    .b_out (b1),
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0])
  );

  half_sub u_hs_br (
    .diff  (d),
    .b_out (b2),
    .a     (t),
    .b     (br_q)
  );

  // New result bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lines up as a normal parallel word.
  if (WIDTH == 1) begin : g_rsh_w1
    assign r_sh_next = d;
  end else begin : g_rsh_wn
    assign r_sh_next = {d, r_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    r_sh_d       = r_sh_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        br_d   = b1 | b2;
        r_sh_d = r_sh_next;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed word and final borrow together.
          state_d      = DONE;
          done_d       = 1'b1;
          diff_d       = r_sh_next;
          borrow_out_d = b1 | b2;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      r_sh_q       <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      r_sh_q       <= r_sh_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign diff_bit   = (state_q == RUN) ? d : 1'b0;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Purpose  : Self-checking bench for serial_sub (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, borrow8, dbit8;
  logic [7:0] diff8;
  logic       busy1, done1, borrow1, dbit1;
  logic [0:0] diff1;

  int checks    = 0;
  int failures  = 0;
  int done_cnt8 = 0;

  logic [8:0] sb_q[$];   // {borrow, diff}

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8),
    .diff_bit(dbit8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1),
    .diff_bit(dbit1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      done_cnt8++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("sb_diff", {24'd0, diff8}, {24'd0, e[7:0]});
        chk("sb_borrow", {31'd0, borrow8}, {31'd0, e[8]});
      end
    end
  end

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] dd;
    dd = a - b;
    return {(a < b), dd};
  endfunction

  // Issue one op on the 8-bit DUT; optionally pulse a stray start mid-RUN.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int inject_at);
    logic [8:0] e;
    logic [7:0] held;
    e = model(a, b);
    held = diff8;
    a8 = a; b8 = b; start8 = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == inject_at) begin
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      chk("run_busy", {31'd0, busy8}, 32'd1);
      chk("run_done_low", {31'd0, done8}, 32'd0);
      chk("run_diff_bit", {31'd0, dbit8}, {31'd0, e[i]});
      chk("run_diff_held", {24'd0, diff8}, {24'd0, held});
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    chk("done_high", {31'd0, done8}, 32'd1);
    chk("done_busy_low", {31'd0, busy8}, 32'd0);
    chk("done_dbit_low", {31'd0, dbit8}, 32'd0);
    @(posedge clk); #1;
    chk("done_pulse_end", {31'd0, done8}, 32'd0);
    chk("idle_busy", {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    #12;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_borrow", {31'd0, borrow8}, 32'd0);
    chk("rst_dbit", {31'd0, dbit8}, 32'd0);
    chk("rst_w1_diff", {31'd0, diff1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and corner operands; diff_bit stream checked inside do_op.
    do_op(8'h05, 8'h03, -1);
    do_op(8'h03, 8'h05, -1);
    do_op(8'h00, 8'h00, -1);
    do_op(8'h00, 8'hFF, -1);
    do_op(8'hFF, 8'hFF, -1);
    do_op(8'hA7, 8'h3C, -1);

    // Stray start during RUN must be ignored.
    dc = done_cnt8;
    do_op(8'h80, 8'h7F, 2);
    @(posedge clk); #1;
    chk("ignored_start_one_done", done_cnt8 - dc, 32'd1);
    chk("ignored_start_idle", {31'd0, busy8}, 32'd0);

    // start held high: back-to-back ops, done pulses 9 cycles apart.
    dc = done_cnt8;
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    sb_q.push_back(model(8'h20, 8'h01));
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h02;
    sb_q.push_back(model(8'h01, 8'h02));
    for (int i = 0; i < 8; i++) begin
      chk("b2b_run1_busy", {31'd0, busy8}, 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b_done1", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_run2_done_low", {31'd0, done8}, 32'd0);
      @(posedge clk); #1;
    end
    chk("b2b_done2", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_two_dones", done_cnt8 - dc, 32'd2);
    chk("b2b_hold_diff", {24'd0, diff8}, 32'hFF);

    // Reset in RUN cycle 4 aborts asynchronously.
    dc = done_cnt8;
    a8 = 8'hC3; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_abort_busy", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_diff", {24'd0, diff8}, 32'd0);
    chk("abort_borrow", {31'd0, borrow8}, 32'd0);
    chk("abort_dbit", {31'd0, dbit8}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt8 - dc, 32'd0);
    do_op(8'h9A, 8'h1B, -1);

    // WIDTH=1: 0 - 1.
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", {31'd0, busy1}, 32'd1);
    chk("w1_dbit", {31'd0, dbit1}, 32'd1);
    chk("w1_no_early_done", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    chk("w1_done", {31'd0, done1}, 32'd1);
    chk("w1_busy_low", {31'd0, busy1}, 32'd0);
    chk("w1_diff", {31'd0, diff1}, 32'd1);
    chk("w1_borrow", {31'd0, borrow1}, 32'd1);
    @(posedge clk); #1;
    chk("w1_done_end", {31'd0, done1}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_sub
`default_nettype wire
